// File: rtl/riscv_pkg.sv
// Shared encodings for the immediate-select field and packer rejection codes.
// immGen decodes the same IMM_* values that instr_packer encodes.
package riscv_pkg;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;

   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_RANGE    = 2'b01;
   localparam logic [1:0] ERR_MISALIGN = 2'b10;
   localparam logic [1:0] ERR_SEL      = 2'b11;

   typedef enum logic {
      ST_FILL = 1'b0,
      ST_FULL = 1'b1
   } pack_state_t;

   // A 12-bit signed immediate fits when bits 31..11 are a pure sign extension.
   function automatic logic imm_fits12(input logic [31:0] imm);
      return (&imm[31:11]) | ~(|imm[31:11]);
   endfunction

endpackage

// File: rtl/instr_packer_imm_pack.sv
// Combinational I/S/B instruction encoder with legality check; exact inverse of immGen.
// Rejection priority: illegal select, then misaligned branch offset, then range.
module imm_pack
   import riscv_pkg::*;
(
   input  logic [1:0]  imm_sel,
   input  logic [6:0]  opcode,
   input  logic [2:0]  funct3,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [31:0] imm,
   output logic [31:0] word,
   output logic        err,
   output logic [1:0]  code
);

   logic fits;

   always_comb begin
      fits = imm_fits12(imm);
      word = 32'h0;
      err  = 1'b0;
      code = ERR_NONE;
      case (imm_sel)
         IMM_I: begin
            word = {imm[11:0], rs1, funct3, rd, opcode};
            if (!fits) begin
               err  = 1'b1;
               code = ERR_RANGE;
            end
         end
         IMM_S: begin
            word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            if (!fits) begin
               err  = 1'b1;
               code = ERR_RANGE;
            end
         end
         IMM_B: begin
            // imm[12] is implied by imm[11] since the legal range is 12-bit signed
            word = {imm[11:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            if (imm[0]) begin
               err  = 1'b1;
               code = ERR_MISALIGN;
            end else if (!fits) begin
               err  = 1'b1;
               code = ERR_RANGE;
            end
         end
         default: begin
            err  = 1'b1;
            code = ERR_SEL;
         end
      endcase
   end

endmodule

// File: rtl/instr_packer.sv
// Packs decoded fields into instruction words and streams legal ones into
// instruction RAM at an auto-incrementing address; rejected bundles are counted.
//
//   state   | meaning
//   ST_FILL | accepting bundles, address counter < DEPTH
//   ST_FULL | DEPTH words written, stalled until clear
module instr_packer
   import riscv_pkg::*;
#(
   parameter int width  = 32,
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        imm_sel,
   input  logic [6:0]        opcode,
   input  logic [2:0]        funct3,
   input  logic [4:0]        rd,
   input  logic [4:0]        rs1,
   input  logic [4:0]        rs2,
   input  logic [width-1:0]  imm,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [width-1:0]  mem_wdata,
   output logic              full,
   output logic              err,
   output logic [1:0]        err_code,
   output logic [7:0]        err_cnt
);

   pack_state_t       state;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       pk_word;
   logic              pk_err;
   logic [1:0]        pk_code;
   logic              accept;

   imm_pack u_imm_pack (
      .imm_sel (imm_sel),
      .opcode  (opcode),
      .funct3  (funct3),
      .rd      (rd),
      .rs1     (rs1),
      .rs2     (rs2),
      .imm     (imm),
      .word    (pk_word),
      .err     (pk_err),
      .code    (pk_code)
   );

   assign in_ready = (state == ST_FILL) && !clear;
   assign accept   = in_valid && in_ready;
   assign full     = (state == ST_FULL);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_FILL;
         addr_q    <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         err       <= 1'b0;
         err_code  <= ERR_NONE;
         err_cnt   <= 8'd0;
      end else begin
         mem_we <= 1'b0;
         // clear leaves mem_addr/mem_wdata alone so a write in flight stays intact
         if (clear) begin
            state    <= ST_FILL;
            addr_q   <= '0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
            err_cnt  <= 8'd0;
         end else if (accept) begin
            if (pk_err) begin
               err <= 1'b1;
               if (!err)
                  err_code <= pk_code;
               if (err_cnt != 8'hFF)
                  err_cnt <= err_cnt + 8'd1;
            end else begin
               mem_we    <= 1'b1;
               mem_addr  <= addr_q;
               mem_wdata <= pk_word;
               if (addr_q == ADDR_W'(DEPTH - 1)) begin
                  state  <= ST_FULL;
                  addr_q <= '0;
               end else begin
                  addr_q <= addr_q + ADDR_W'(1);
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_instr_packer.sv
// Directed bench for instr_packer (DEPTH=4) with a per-cycle behavioural model
// and an immGen-style decoder for round-trip checks.
module tb_instr_packer;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        clear = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [1:0]  imm_sel = 2'b00;
   logic [6:0]  opcode = 7'h0;
   logic [2:0]  funct3 = 3'h0;
   logic [4:0]  rd = 5'h0, rs1 = 5'h0, rs2 = 5'h0;
   logic [31:0] imm = 32'h0;
   logic        mem_we;
   logic [1:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic        full, err;
   logic [1:0]  err_code;
   logic [7:0]  err_cnt;

   int total = 0;
   int bad = 0;
   bit chk_on = 1'b0;

   instr_packer #(.width(32), .DEPTH(DEPTH), .ADDR_W(2)) dut (
      .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
      .imm_sel(imm_sel), .opcode(opcode), .funct3(funct3), .rd(rd), .rs1(rs1), .rs2(rs2),
      .imm(imm), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .full(full), .err(err), .err_code(err_code), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Encoder built from field positions by arithmetic, independent of the RTL.
   function automatic void model_pack(input int sel, input int op, input int f3, input int d,
                                      input int s1, input int s2, input int signed v,
                                      output logic [31:0] w, output int code);
      int u;
      int hi;
      u = v & 'hFFF;
      hi = (sel == 2) ? 2046 : 2047;
      if (sel == 3) code = 3;
      else if (sel == 2 && (v % 2) != 0) code = 2;
      else if (v < -2048 || v > hi) code = 1;
      else code = 0;
      w = op + (f3 << 12) + (s1 << 15);
      case (sel)
         0: w = w + (d << 7) + (u << 20);
         1: w = w + ((u & 31) << 7) + (s2 << 20) + ((u >> 5) << 25);
         2: w = w + (((u >> 1) & 15) << 8) + (((u >> 11) & 1) << 7) + (s2 << 20) + ((u >> 5) << 25);
         default: w = 32'h0;
      endcase
   endfunction

   // Standard immGen decode.
   function automatic logic [31:0] imm_gen(input logic [31:0] w, input logic [1:0] sel);
      logic [31:0] r;
      case (sel)
         2'b00: r = {{20{w[31]}}, w[31:20]};
         2'b01: r = {{20{w[31]}}, w[31:25], w[11:7]};
         2'b10: r = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
         default: r = 32'h0;
      endcase
      return r;
   endfunction

   // Behavioural model state
   bit          m_full = 0;
   int          m_addr = 0;
   bit          m_we = 0;
   int          m_maddr = 0;
   logic [31:0] m_wdata = 0;
   bit          m_err = 0;
   int          m_code = 0;
   int          m_cnt = 0;

   always @(posedge clk) begin
      logic [31:0] w;
      int code;
      if (reset) begin
         m_full = 0; m_addr = 0; m_we = 0; m_maddr = 0; m_wdata = 0;
         m_err = 0; m_code = 0; m_cnt = 0;
      end else begin
         m_we = 0;
         if (clear) begin
            m_full = 0; m_addr = 0; m_err = 0; m_code = 0; m_cnt = 0;
         end else if (in_valid && !m_full) begin
            model_pack(int'(imm_sel), int'(opcode), int'(funct3), int'(rd), int'(rs1),
                       int'(rs2), int'(signed'(imm)), w, code);
            if (code != 0) begin
               if (!m_err) m_code = code;
               m_err = 1;
               if (m_cnt < 255) m_cnt++;
            end else begin
               m_we = 1;
               m_maddr = m_addr;
               m_wdata = w;
               if (m_addr == DEPTH - 1) m_full = 1;
               m_addr = (m_addr + 1) % DEPTH;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         chk("mem_we", 32'(mem_we), 32'(m_we));
         chk("mem_addr", 32'(mem_addr), 32'(m_maddr));
         chk("mem_wdata", mem_wdata, m_wdata);
         chk("full", 32'(full), 32'(m_full));
         chk("err", 32'(err), 32'(m_err));
         chk("err_code", 32'(err_code), 32'(m_code));
         chk("err_cnt", 32'(err_cnt), 32'(m_cnt));
         chk("in_ready", 32'(in_ready), 32'(!m_full && !clear));
      end
   end

   task automatic drive(input logic [1:0] s, input logic [6:0] op, input logic [2:0] f3,
                        input logic [4:0] d, input logic [4:0] a, input logic [4:0] b,
                        input logic [31:0] v);
      imm_sel = s; opcode = op; funct3 = f3; rd = d; rs1 = a; rs2 = b; imm = v;
      in_valid = 1'b1;
   endtask

   // Offer a bundle, wait for the handshake edge, return 2 time units after it.
   task automatic send(input logic [1:0] s, input logic [6:0] op, input logic [2:0] f3,
                       input logic [4:0] d, input logic [4:0] a, input logic [4:0] b,
                       input logic [31:0] v);
      bit done;
      done = 0;
      drive(s, op, f3, d, a, b, v);
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         if (in_ready) done = 1;
      end
      if (!done) begin
         total++; bad++;
         $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 20 cycles");
      end
      @(posedge clk); #2;
      in_valid = 1'b0;
   endtask

   initial begin
      @(posedge clk); #2;
      chk_on = 1'b1;
      @(posedge clk); #2;
      reset = 1'b0;
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_err_cnt", 32'(err_cnt), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      send(2'b00, 7'b0010011, 3'b000, 5'd1, 5'd0, 5'd0, 32'd5);
      chk("i_we", 32'(mem_we), 32'd1);
      chk("i_addr", 32'(mem_addr), 32'd0);
      chk("i_data", mem_wdata, 32'h00500093);

      send(2'b01, 7'b0100011, 3'b010, 5'd0, 5'd3, 5'd2, 32'd8);
      chk("s_addr", 32'(mem_addr), 32'd1);
      chk("s_data", mem_wdata, 32'h0021A423);
      chk("s_roundtrip", imm_gen(mem_wdata, 2'b01), 32'd8);

      send(2'b10, 7'b1100011, 3'b000, 5'd0, 5'd1, 5'd2, -32'sd4);
      chk("b_addr", 32'(mem_addr), 32'd2);
      chk("b_data", mem_wdata, 32'hFE208EE3);
      chk("b_roundtrip", imm_gen(mem_wdata, 2'b10), 32'hFFFFFFFC);

      send(2'b00, 7'b0010011, 3'b000, 5'd1, 5'd0, 5'd0, 32'd2048);
      chk("rng_we", 32'(mem_we), 32'd0);
      chk("rng_err", 32'(err), 32'd1);
      chk("rng_code", 32'(err_code), 32'd1);
      chk("rng_cnt", 32'(err_cnt), 32'd1);
      send(2'b10, 7'b1100011, 3'b000, 5'd0, 5'd1, 5'd2, 32'd3);
      chk("mis_cnt", 32'(err_cnt), 32'd2);
      chk("mis_code_kept", 32'(err_code), 32'd1);
      send(2'b11, 7'b0010011, 3'b000, 5'd1, 5'd0, 5'd0, 32'd0);
      chk("sel_cnt", 32'(err_cnt), 32'd3);
      chk("sel_we", 32'(mem_we), 32'd0);
      // boundary legal values
      send(2'b10, 7'b1100011, 3'b001, 5'd0, 5'd4, 5'd5, 32'd2046);
      chk("b_max_addr", 32'(mem_addr), 32'd3);
      chk("b_max_roundtrip", imm_gen(mem_wdata, 2'b10), 32'd2046);
      chk("b_max_full", 32'(full), 32'd1);

      // clear coinciding with a valid bundle: not accepted
      drive(2'b00, 7'b0010011, 3'b000, 5'd7, 5'd0, 5'd0, 32'd1);
      clear = 1'b1;
      @(negedge clk);
      chk("clr_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #2;
      clear = 1'b0; in_valid = 1'b0;
      chk("clr_we", 32'(mem_we), 32'd0);
      chk("clr_err", 32'(err), 32'd0);
      chk("clr_full", 32'(full), 32'd0);

      for (int i = 0; i < DEPTH; i++) begin
         send(2'b00, 7'b0010011, 3'b000, 5'(i + 1), 5'd0, 5'd0, 32'(-2048 + i));
         chk("fill_addr", 32'(mem_addr), 32'(i));
         chk("fill_roundtrip", imm_gen(mem_wdata, 2'b00), 32'(-2048 + i));
      end
      chk("last_full", 32'(full), 32'd1);
      chk("last_we", 32'(mem_we), 32'd1);
      drive(2'b01, 7'b0100011, 3'b000, 5'd0, 5'd9, 5'd10, 32'd2047);
      repeat (3) begin
         @(negedge clk);
         chk("stall_ready", 32'(in_ready), 32'd0);
      end
      @(posedge clk); #2;
      clear = 1'b1;
      @(posedge clk); #2;
      clear = 1'b0;
      send(2'b01, 7'b0100011, 3'b000, 5'd0, 5'd9, 5'd10, 32'd2047);
      chk("fifth_addr", 32'(mem_addr), 32'd0);
      chk("fifth_we", 32'(mem_we), 32'd1);
      chk("fifth_roundtrip", imm_gen(mem_wdata, 2'b01), 32'd2047);

      // error counter saturation
      drive(2'b11, 7'b0, 3'b0, 5'd0, 5'd0, 5'd0, 32'd0);
      repeat (260) @(posedge clk);
      #2 in_valid = 1'b0;
      chk("sat_cnt", 32'(err_cnt), 32'd255);
      chk("sat_code", 32'(err_code), 32'd3);

      // reset at the same edge as an offered bundle
      drive(2'b00, 7'b0010011, 3'b000, 5'd1, 5'd0, 5'd0, 32'd5);
      reset = 1'b1;
      @(posedge clk); #2;
      reset = 1'b0; in_valid = 1'b0;
      chk("rst_same_we", 32'(mem_we), 32'd0);
      chk("rst_same_cnt", 32'(err_cnt), 32'd0);
      chk("rst_same_data", mem_wdata, 32'd0);

      // reset the edge after an accept
      send(2'b00, 7'b0010011, 3'b000, 5'd2, 5'd0, 5'd0, 32'd6);
      chk("pre_rst_we", 32'(mem_we), 32'd1);
      reset = 1'b1;
      @(posedge clk); #2;
      reset = 1'b0;
      chk("post_rst_we", 32'(mem_we), 32'd0);
      chk("post_rst_addr", 32'(mem_addr), 32'd0);
      chk("post_rst_data", mem_wdata, 32'd0);
      repeat (2) @(posedge clk);
      #2;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
